// File: rtl/seq_stream_checker.sv
// seq_stream_checker: consumer-end checker for incrementing addr/data stream runs.
// Define SEQ_CHK_BACKPRESSURE_EN to build an LFSR that randomly throttles ready_out.
module seq_stream_checker #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned ADDR_WIDTH  = 32,
  parameter int unsigned CNT_WIDTH   = 16,
  parameter bit          STOP_ON_ERR = 1'b0,
  parameter logic [15:0] LFSR_SEED   = 16'hACE1
) (
  input  logic                  clk,
  input  logic                  sys_rst,
  input  logic                  valid_in,
  output logic                  ready_out,
  input  logic [ADDR_WIDTH-1:0] addr_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  clear_in,
  output logic [CNT_WIDTH-1:0]  beat_cnt,
  output logic [CNT_WIDTH-1:0]  err_cnt,
  output logic                  err_pulse,
  output logic                  err_sticky,
  output logic [ADDR_WIDTH-1:0] first_err_addr,
  output logic [DATA_WIDTH-1:0] first_err_data
);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, FAULT = 2'd2} state_e;

  state_e                state_q;
  logic                  ready_q;
  logic                  err_pulse_q;
  logic                  err_sticky_q;
  logic [ADDR_WIDTH-1:0] exp_addr_q, first_err_addr_q;
  logic [DATA_WIDTH-1:0] exp_data_q, first_err_data_q;
  logic [CNT_WIDTH-1:0]  beat_cnt_q, err_cnt_q;

  logic                  accept, mismatch, enter_fault, bp_ok;
  logic [CNT_WIDTH-1:0]  beat_cnt_d, err_cnt_d;
  logic [ADDR_WIDTH-1:0] exp_addr_d;
  logic [DATA_WIDTH-1:0] exp_data_d;

`ifdef SEQ_CHK_BACKPRESSURE_EN
  logic [15:0] lfsr_q, lfsr_d;

  assign lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) lfsr_q <= LFSR_SEED;
    else         lfsr_q <= lfsr_d;
  end

  // ready is registered, so it is computed from the LFSR value it will sit beside
  assign bp_ok = (lfsr_d[1:0] != 2'b00);
`else
  assign bp_ok = 1'b1;
`endif

  assign accept      = valid_in & ready_q;
  assign mismatch    = (addr_in != exp_addr_q) || (data_in != exp_data_q);
  assign enter_fault = STOP_ON_ERR && accept && mismatch;

  // Counters stick at all-ones instead of wrapping
  assign beat_cnt_d  = (&beat_cnt_q) ? beat_cnt_q : beat_cnt_q + CNT_WIDTH'(1);
  assign err_cnt_d   = (&err_cnt_q)  ? err_cnt_q  : err_cnt_q  + CNT_WIDTH'(1);

  // Both match and resync leave the expectation at received + 1
  assign exp_addr_d  = addr_in + ADDR_WIDTH'(1);
  assign exp_data_d  = data_in + DATA_WIDTH'(1);

  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q          <= IDLE;
      ready_q          <= 1'b0;
      err_pulse_q      <= 1'b0;
      err_sticky_q     <= 1'b0;
      exp_addr_q       <= '0;
      exp_data_q       <= '0;
      first_err_addr_q <= '0;
      first_err_data_q <= '0;
      beat_cnt_q       <= '0;
      err_cnt_q        <= '0;
    end else begin
      err_pulse_q <= 1'b0;
      if (clear_in) begin
        // clear wins over any beat on the same edge
        state_q          <= IDLE;
        ready_q          <= bp_ok;
        err_sticky_q     <= 1'b0;
        exp_addr_q       <= '0;
        exp_data_q       <= '0;
        first_err_addr_q <= '0;
        first_err_data_q <= '0;
        beat_cnt_q       <= '0;
        err_cnt_q        <= '0;
      end else begin
        case (state_q)
          IDLE, RUN: begin
            ready_q <= bp_ok & ~enter_fault;
            if (accept) begin
              beat_cnt_q <= beat_cnt_d;
              if (mismatch) begin
                err_pulse_q <= 1'b1;
                err_cnt_q   <= err_cnt_d;
                if (!err_sticky_q) begin
                  err_sticky_q     <= 1'b1;
                  first_err_addr_q <= addr_in;
                  first_err_data_q <= data_in;
                end
              end
              if (enter_fault) begin
                state_q    <= FAULT;
                exp_addr_q <= '0;
                exp_data_q <= '0;
              end else begin
                state_q    <= RUN;
                exp_addr_q <= exp_addr_d;
                exp_data_q <= exp_data_d;
              end
            end else if (!valid_in) begin
              // a stall with valid held is not a run break
              state_q    <= IDLE;
              exp_addr_q <= '0;
              exp_data_q <= '0;
            end
          end
          FAULT: begin
            ready_q <= 1'b0;
          end
          default: begin
            state_q <= IDLE;
            ready_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign ready_out      = ready_q;
  assign beat_cnt       = beat_cnt_q;
  assign err_cnt        = err_cnt_q;
  assign err_pulse      = err_pulse_q;
  assign err_sticky     = err_sticky_q;
  assign first_err_addr = first_err_addr_q;
  assign first_err_data = first_err_data_q;

endmodule

// File: tb/tb_seq_stream_checker.sv
// Bench for seq_stream_checker: scoreboard against a run-level reference model,
// plus directed STOP_ON_ERR and narrow-width/saturation instances.
module tb_seq_stream_checker;
  logic clk = 1'b0;
  logic sys_rst = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  // main instance: 32-bit, resync on error
  logic        va = 1'b0, clra = 1'b0, ra, pa, sa;
  logic [31:0] aa = '0, da = '0, faa, fda;
  logic [15:0] bca, eca;
  seq_stream_checker #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .CNT_WIDTH(16), .STOP_ON_ERR(1'b0))
    u_a (.clk(clk), .sys_rst(sys_rst), .valid_in(va), .ready_out(ra), .addr_in(aa), .data_in(da),
         .clear_in(clra), .beat_cnt(bca), .err_cnt(eca), .err_pulse(pa), .err_sticky(sa),
         .first_err_addr(faa), .first_err_data(fda));

  // stop-on-error instance
  logic        vb = 1'b0, clrb = 1'b0, rb, pb, sb;
  logic [31:0] ab = '0, db = '0, fab, fdb;
  logic [15:0] bcb, ecb;
  seq_stream_checker #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .CNT_WIDTH(16), .STOP_ON_ERR(1'b1))
    u_b (.clk(clk), .sys_rst(sys_rst), .valid_in(vb), .ready_out(rb), .addr_in(ab), .data_in(db),
         .clear_in(clrb), .beat_cnt(bcb), .err_cnt(ecb), .err_pulse(pb), .err_sticky(sb),
         .first_err_addr(fab), .first_err_data(fdb));

  // narrow instance: 4-bit addr/data, 4-bit counters
  logic       vc = 1'b0, clrc = 1'b0, rc, pc, sc;
  logic [3:0] ac = '0, dc = '0, fac, fdc, bcc, ecc;
  seq_stream_checker #(.DATA_WIDTH(4), .ADDR_WIDTH(4), .CNT_WIDTH(4), .STOP_ON_ERR(1'b0))
    u_c (.clk(clk), .sys_rst(sys_rst), .valid_in(vc), .ready_out(rc), .addr_in(ac), .data_in(dc),
         .clear_in(clrc), .beat_cnt(bcc), .err_cnt(ecc), .err_pulse(pc), .err_sticky(sc),
         .first_err_addr(fac), .first_err_data(fdc));

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  task automatic fail_now(input string nm);
    n_chk++;
    $display("FAIL %s: timed out waiting for the DUT", nm);
  endtask

  // ---------------- reference model (run semantics) ----------------
  typedef struct {
    int unsigned beats;
    int unsigned errs;
    bit          pulse;
    bit          sticky;
    logic [31:0] fa;
    logic [31:0] fd;
  } resp_t;
  resp_t q[$];

  bit          m_run;
  logic [31:0] m_last_a, m_last_d, m_fa, m_fd;
  int unsigned m_beats, m_errs;
  bit          m_sticky;

  task automatic m_clear();
    m_run = 0; m_last_a = '0; m_last_d = '0;
    m_beats = 0; m_errs = 0; m_sticky = 0; m_fa = '0; m_fd = '0;
  endtask

  task automatic m_accept(input logic [31:0] a, input logic [31:0] d);
    resp_t r;
    logic [31:0] ea, ed;
    bit bad;
    // a run starts at 0; otherwise the next beat is the previous one plus 1
    ea = m_run ? m_last_a + 32'd1 : 32'd0;
    ed = m_run ? m_last_d + 32'd1 : 32'd0;
    bad = (a != ea) || (d != ed);
    if (m_beats < 65535) m_beats++;
    if (bad) begin
      if (m_errs < 65535) m_errs++;
      if (!m_sticky) begin m_sticky = 1; m_fa = a; m_fd = d; end
    end
    m_last_a = a; m_last_d = d; m_run = 1;
    r.beats = m_beats; r.errs = m_errs; r.pulse = bad;
    r.sticky = m_sticky; r.fa = m_fa; r.fd = m_fd;
    q.push_back(r);
  endtask

  // ---------------- monitor for the main instance ----------------
  logic acc_seen = 1'b0;
  always @(posedge clk) acc_seen <= va & ra & ~clra & ~sys_rst;

  always @(negedge clk) begin
    resp_t e;
    if (acc_seen) begin
      if (q.size() == 0) begin
        n_chk++;
        $display("FAIL A_scoreboard: beat accepted with no expected response queued");
      end else begin
        e = q.pop_front();
        chk("A_beat_cnt",   64'(bca), 64'(e.beats));
        chk("A_err_cnt",    64'(eca), 64'(e.errs));
        chk("A_err_pulse",  64'(pa),  64'(e.pulse));
        chk("A_err_sticky", 64'(sa),  64'(e.sticky));
        chk("A_first_addr", 64'(faa), 64'(e.fa));
        chk("A_first_data", 64'(fda), 64'(e.fd));
      end
    end else if (!sys_rst) begin
      chk("A_pulse_quiet", 64'(pa), 64'd0);
    end
  end

  // ---------------- drivers ----------------
  task automatic sendA(input logic [31:0] a, input logic [31:0] d);
    int w = 0;
    va = 1'b1; aa = a; da = d;
    while (ra !== 1'b1 && w <= 64) begin @(negedge clk); w++; end
    if (w > 64) begin fail_now("A_ready_wait"); return; end
    m_accept(a, d);
    @(negedge clk);
  endtask

  task automatic gapA(input int n);
    va = 1'b0;
    repeat (n) begin m_run = 0; @(negedge clk); end
  endtask

  task automatic clearA(input bit with_beat);
    clra = 1'b1; va = with_beat; aa = '0; da = '0;
    @(negedge clk);
    clra = 1'b0; va = 1'b0;
    m_clear();
    chk("A_clr_beat_cnt", 64'(bca), 64'd0);
    chk("A_clr_err_cnt",  64'(eca), 64'd0);
    chk("A_clr_sticky",   64'(sa),  64'd0);
  endtask

  task automatic waitB(output bit ok);
    int w = 0;
    while (rb !== 1'b1 && w <= 64) begin @(negedge clk); w++; end
    ok = (w <= 64);
    if (!ok) fail_now("B_ready_wait");
  endtask

  task automatic waitC(output bit ok);
    int w = 0;
    while (rc !== 1'b1 && w <= 64) begin @(negedge clk); w++; end
    ok = (w <= 64);
    if (!ok) fail_now("C_ready_wait");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int unsigned len;
    logic [31:0] a, d;
    bit ok;
    m_clear();

    // reset state
    #1 sys_rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ready",    64'(ra),  64'd0);
    chk("rst_beat_cnt", 64'(bca), 64'd0);
    chk("rst_err_cnt",  64'(eca), 64'd0);
    chk("rst_sticky",   64'(sa),  64'd0);
    sys_rst = 1'b0;
    #1 chk("rst_ready_hold", 64'(ra), 64'd0);
    @(negedge clk);
`ifndef SEQ_CHK_BACKPRESSURE_EN
    chk("ready_after_rst", 64'(ra), 64'd1);
`endif

    // clean run of 20 beats
    for (int i = 0; i < 20; i++) sendA(32'(i), 32'(i));
    gapA(1);
    chk("t1_beat_cnt", 64'(bca), 64'd20);
    chk("t1_err_cnt",  64'(eca), 64'd0);
    chk("t1_sticky",   64'(sa),  64'd0);

    // run break: 0..4, gap, 0..2
    clearA(1'b0);
    for (int i = 0; i < 5; i++) sendA(32'(i), 32'(i));
    gapA(1);
    for (int i = 0; i < 3; i++) sendA(32'(i), 32'(i));
    gapA(1);
    chk("t2_beat_cnt", 64'(bca), 64'd8);
    chk("t2_err_cnt",  64'(eca), 64'd0);

    // corrupt data on beat 7, then beat 8 mismatches the resynced expectation
    clearA(1'b0);
    for (int i = 0; i < 7; i++) sendA(32'(i), 32'(i));
    sendA(32'd7, 32'h55);
    chk("t3_pulse",      64'(pa),  64'd1);
    chk("t3_err_cnt",    64'(eca), 64'd1);
    chk("t3_first_addr", 64'(faa), 64'd7);
    chk("t3_first_data", 64'(fda), 64'h55);
    sendA(32'd8, 32'd8);
    chk("t3_err_cnt2",   64'(eca), 64'd2);
    chk("t3_first_addr2",64'(faa), 64'd7);
    chk("t3_first_data2",64'(fda), 64'h55);
    gapA(1);

    // a beat on the clear edge is discarded: next run must start at 0
    clearA(1'b1);
    sendA(32'd0, 32'd0);
    sendA(32'd1, 32'd1);
    gapA(2);

    // randomized runs with occasional corruption, gaps and clears
    for (int r = 0; r < 40; r++) begin
      len = $urandom_range(1, 20);
      for (int i = 0; i < int'(len); i++) begin
        a = 32'(i); d = 32'(i);
        if ($urandom_range(0, 9) == 0)  d = $urandom;
        if ($urandom_range(0, 14) == 0) a = $urandom;
        sendA(a, d);
      end
      gapA(int'($urandom_range(1, 2)));
      if ($urandom_range(0, 7) == 0) clearA(bit'($urandom_range(0, 1)));
    end

    // async reset in the middle of a run
    for (int i = 0; i < 6; i++) sendA(32'(i), (i == 3) ? 32'h99 : 32'(i));
    #2 sys_rst = 1'b1; va = 1'b0;
    #1;
    chk("arst_ready",     64'(ra),  64'd0);
    chk("arst_beat_cnt",  64'(bca), 64'd0);
    chk("arst_err_cnt",   64'(eca), 64'd0);
    chk("arst_pulse",     64'(pa),  64'd0);
    chk("arst_sticky",    64'(sa),  64'd0);
    chk("arst_first_addr",64'(faa), 64'd0);
    chk("arst_first_data",64'(fda), 64'd0);
    m_clear();
    q.delete();
    @(negedge clk); sys_rst = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 5; i++) sendA(32'(i), 32'(i));
    gapA(1);
    chk("arst_rerun_cnt", 64'(bca), 64'd5);
    chk("arst_rerun_err", 64'(eca), 64'd0);

    // STOP_ON_ERR: first beat addr=3 faults
    vb = 1'b1; ab = 32'd3; db = 32'd0;
    waitB(ok);
    @(negedge clk);
    ab = 32'd4; db = 32'd1;
    chk("B_fault_ready", 64'(rb),  64'd0);
    chk("B_beat_cnt",    64'(bcb), 64'd1);
    chk("B_err_cnt",     64'(ecb), 64'd1);
    chk("B_first_addr",  64'(fab), 64'd3);
    repeat (4) @(negedge clk);
    chk("B_fault_hold_ready", 64'(rb),  64'd0);
    chk("B_fault_hold_cnt",   64'(bcb), 64'd1);
    clrb = 1'b1; vb = 1'b0;
    @(negedge clk);
    clrb = 1'b0;
    chk("B_clr_beat_cnt", 64'(bcb), 64'd0);
    chk("B_clr_err_cnt",  64'(ecb), 64'd0);
    chk("B_clr_sticky",   64'(sb),  64'd0);
`ifndef SEQ_CHK_BACKPRESSURE_EN
    chk("B_clr_ready",    64'(rb),  64'd1);
`endif
    vb = 1'b1; ab = 32'd0; db = 32'd0;
    waitB(ok);
    @(negedge clk);
    vb = 1'b0;
    chk("B_idle_beat_cnt", 64'(bcb), 64'd1);
    chk("B_idle_err_cnt",  64'(ecb), 64'd0);

    // 4-bit wrap 0..15,0 then clear on the 18th accepting edge; counters saturate at 15
    for (int i = 0; i < 17; i++) begin
      vc = 1'b1; ac = 4'(i); dc = 4'(i);
      waitC(ok);
      @(negedge clk);
      chk("C_pulse", 64'(pc), 64'd0);
    end
    chk("C_err_cnt", 64'(ecc), 64'd0);
    chk("C_beat_sat", 64'(bcc), 64'd15);
    chk("C_sticky",  64'(sc),  64'd0);
    ac = 4'd1; dc = 4'd1; clrc = 1'b1;
    waitC(ok);
    @(negedge clk);
    clrc = 1'b0; vc = 1'b0;
    chk("C_clr_beat_cnt", 64'(bcc), 64'd0);
    chk("C_clr_err_cnt",  64'(ecc), 64'd0);

    repeat (2) @(negedge clk);
    if (q.size() != 0) begin
      n_chk++;
      $display("FAIL A_scoreboard_drain: %0d responses never observed, expected 0", q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
